// File: rtl/uart_hd_tx.sv
// Half-duplex 8N1 UART transmitter that also owns the pad output-enable for a shared line.
// Latency: oe rises the edge after accept; start bit follows TURN_CYCLES later; 10*CLKS_PER_BIT per byte.
// Backpressure: tx_ready only in IDLE and the last STOP cycle; tx_valid at any other time is ignored.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   tx_data[7:0]    byte to send, captured on the accept edge
//   tx_valid        producer has a byte
//   tx_ready        block can take a byte (decoded from state, forced low in reset)
//   oe              registered pad output-enable, high from accept through the trailing guard
//   tx_out          registered serial level to the pad, idles at 1
//   busy            high in every state other than IDLE
module uart_hd_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int TURN_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       oe,
    output logic       tx_out,
    output logic       busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_TAIL  = 3'd5;

    localparam int BW = $clog2(CLKS_PER_BIT);
    // A zero-length guard still needs a 1-bit counter to exist; it is never advanced.
    localparam int GW = (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;

    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE   = BW'(1);
    localparam logic [GW-1:0] GUARD_LAST = GW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
    localparam logic [GW-1:0] GUARD_ONE  = GW'(1);

    logic [2:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [GW-1:0] guard_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;
    logic          accept;

    assign bit_end  = (baud_cnt == BAUD_LAST);
    // Ready in the final STOP cycle lets a queued byte chain straight into the next start bit.
    assign tx_ready = !rst && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
    assign accept   = tx_valid && tx_ready;
    assign busy     = (state != S_IDLE);

    // tx_out and oe are loaded with the level of the state being entered, so the
    // registered outputs line up with the state register on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            oe        <= 1'b0;
            tx_out    <= 1'b1;
            baud_cnt  <= '0;
            guard_cnt <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        shreg     <= tx_data;
                        oe        <= 1'b1;
                        baud_cnt  <= '0;
                        guard_cnt <= '0;
                        bit_idx   <= '0;
                        if (TURN_CYCLES == 0) begin
                            state  <= S_START;
                            tx_out <= 1'b0;
                        end else begin
                            state  <= S_LEAD;
                            tx_out <= 1'b1;
                        end
                    end
                end
                S_LEAD: begin
                    if (guard_cnt == GUARD_LAST) begin
                        guard_cnt <= '0;
                        state     <= S_START;
                        tx_out    <= 1'b0;
                    end else begin
                        guard_cnt <= guard_cnt + GUARD_ONE;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= S_DATA;
                        tx_out   <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= S_STOP;
                            tx_out  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            // Next bit is shreg[1] before the shift lands.
                            tx_out  <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        guard_cnt <= '0;
                        if (accept) begin
                            // Back-to-back: keep the line driven, no turnaround guards.
                            shreg   <= tx_data;
                            bit_idx <= '0;
                            state   <= S_START;
                            tx_out  <= 1'b0;
                        end else if (TURN_CYCLES == 0) begin
                            state  <= S_IDLE;
                            oe     <= 1'b0;
                            tx_out <= 1'b1;
                        end else begin
                            state  <= S_TAIL;
                            tx_out <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                S_TAIL: begin
                    if (guard_cnt == GUARD_LAST) begin
                        guard_cnt <= '0;
                        state     <= S_IDLE;
                        oe        <= 1'b0;
                    end else begin
                        guard_cnt <= guard_cnt + GUARD_ONE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    oe        <= 1'b0;
                    tx_out    <= 1'b1;
                    baud_cnt  <= '0;
                    guard_cnt <= '0;
                    bit_idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hd_tx.sv
// Bench for uart_hd_tx: two instances (N=16/T=2 and N=4/T=0) checked cycle by cycle
// against a frame-timing model computed from accept-edge arithmetic.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_uart_hd_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_a, data_b;
    logic       vld_a, vld_b;
    logic       rdy_a, oe_a, out_a, busy_a;
    logic       rdy_b, oe_b, out_b, busy_b;

    always #5 clk = ~clk;

    uart_hd_tx #(.CLKS_PER_BIT(16), .TURN_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .tx_data(data_a), .tx_valid(vld_a),
        .tx_ready(rdy_a), .oe(oe_a), .tx_out(out_a), .busy(busy_a)
    );

    uart_hd_tx #(.CLKS_PER_BIT(4), .TURN_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .tx_data(data_b), .tx_valid(vld_b),
        .tx_ready(rdy_b), .oe(oe_b), .tx_out(out_b), .busy(busy_b)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] frm [4];

    function automatic int nbit(input int sel);
        return (sel != 0) ? 4 : 16;
    endfunction

    function automatic int tguard(input int sel);
        return (sel != 0) ? 0 : 2;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s c=%0d observed=%b expected=%b", tag, c, obs, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic v, input logic [7:0] d);
        if (sel != 0) begin
            vld_b = v; data_b = d;
        end else begin
            vld_a = v; data_a = d;
        end
    endtask

    task automatic sample(input int sel, output logic o, output logic t, output logic b, output logic r);
        if (sel != 0) begin
            o = oe_b; t = out_b; b = busy_b; r = rdy_b;
        end else begin
            o = oe_a; t = out_a; b = busy_a; r = rdy_a;
        end
    endtask

    // Expected outputs after edge c, where edge 0 accepted frm[0] and the remaining
    // m-1 bytes chain back-to-back (each start bit right after the previous stop bit).
    task automatic model(input int sel, input int m, input int c,
                         output logic e_oe, output logic e_out, output logic e_busy, output logic e_rdy);
        int n, t, span, endc, d, i, s;
        logic [7:0] b;
        n = nbit(sel); t = tguard(sel); span = 10 * n;
        endc = 2 * t + span * m;
        e_oe   = (c < endc);
        e_busy = (c < endc);
        e_rdy  = (c >= endc);
        for (int k = 0; k < m; k++)
            if (c == t + span * (k + 1) - 1) e_rdy = 1'b1;
        e_out = 1'b1;
        if (c >= t && c < t + span * m) begin
            d = c - t;
            i = d / span;
            s = (d % span) / n;
            if (s == 0) e_out = 1'b0;
            else if (s <= 8) begin
                b = frm[i];
                e_out = b[s - 1];
            end
        end
    endtask

    // Sends frm[0..m-1] starting from IDLE and checks every cycle until back in IDLE.
    // glitch_c: cycle after which a 0xFF tx_valid pulse is driven (-1 = none).
    // abort_c: return just after edge abort_c without checking (-1 = run to end).
    task automatic run_frames(input int sel, input int m, input int glitch_c, input int abort_c);
        int n, t, span, endc, acc;
        logic o, tx, b, r, eo, et, eb, er;
        n = nbit(sel); t = tguard(sel); span = 10 * n;
        endc = 2 * t + span * m;
        set_in(sel, 1'b1, frm[0]);
        step;
        for (int c = 0; c <= endc; c++) begin
            if (c == abort_c) return;
            model(sel, m, c, eo, et, eb, er);
            sample(sel, o, tx, b, r);
            chk("oe", c, o, eo);
            chk("tx_out", c, tx, et);
            chk("busy", c, b, eb);
            chk("tx_ready", c, r, er);
            acc = 1;
            for (int k = 1; k < m; k++)
                if (t + span * k <= c) acc++;
            if (acc < m) set_in(sel, 1'b1, frm[acc]);
            else if (c == glitch_c) set_in(sel, 1'b1, 8'hFF);
            else set_in(sel, 1'b0, 8'h00);
            step;
        end
        set_in(sel, 1'b0, 8'h00);
    endtask

    task automatic chk_idle(input string tag, input int sel, input logic exp_rdy);
        logic o, tx, b, r;
        sample(sel, o, tx, b, r);
        chk({tag, "_oe"}, 0, o, 1'b0);
        chk({tag, "_tx_out"}, 0, tx, 1'b1);
        chk({tag, "_busy"}, 0, b, 1'b0);
        chk({tag, "_tx_ready"}, 0, r, exp_rdy);
    endtask

    initial begin
        int m, sel;
        rst = 1'b1;
        vld_a = 1'b0; data_a = 8'h00;
        vld_b = 1'b0; data_b = 8'h00;
        step;
        step;
        chk_idle("reset_a", 0, 1'b0);
        chk_idle("reset_b", 1, 1'b0);
        rst = 1'b0;
        #1;
        chk_idle("post_reset_a", 0, 1'b1);
        chk_idle("post_reset_b", 1, 1'b1);
        step;

        // Single byte 0xA5, N=16 T=2.
        frm[0] = 8'hA5;
        run_frames(0, 1, -1, -1);

        // Back-to-back 0x55 then 0x0F with tx_valid held.
        frm[0] = 8'h55; frm[1] = 8'h0F;
        run_frames(0, 2, -1, -1);

        // Zero guard: N=4 T=0, 0x00.
        frm[0] = 8'h00;
        run_frames(1, 1, -1, -1);

        // 0xFF pulsed mid-frame must be ignored.
        frm[0] = 8'($urandom);
        run_frames(0, 1, 50, -1);
        frm[0] = 8'($urandom);
        run_frames(1, 1, 10, -1);

        // Random bursts on either instance.
        for (int r = 0; r < 6; r++) begin
            m = $urandom_range(1, 3);
            sel = $urandom_range(0, 1);
            for (int k = 0; k < 4; k++) frm[k] = 8'($urandom);
            run_frames(sel, m, -1, -1);
            step;
        end

        // Reset in DATA bit 3 (cycles 66..81 for N=16 T=2).
        frm[0] = 8'($urandom);
        run_frames(0, 1, -1, 70);
        rst = 1'b1;
        step;
        chk_idle("abort", 0, 1'b0);
        rst = 1'b0;
        #1;
        chk_idle("abort_release", 0, 1'b1);
        step;
        frm[0] = 8'h3C;
        run_frames(0, 1, -1, -1);

        // Reset and accept on the same edge: byte dropped.
        rst = 1'b1;
        set_in(0, 1'b1, 8'h99);
        step;
        chk_idle("rst_accept", 0, 1'b0);
        rst = 1'b0;
        set_in(0, 1'b0, 8'h00);
        step;
        chk_idle("rst_accept_after", 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
